// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: RAM write port, Gray write pointer, full/level/overflow.
// Optional almost-full output wafull is built when FIFO_WR_AFULL_EN is defined.
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 2
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wclken,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  wfull,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  wovf
`ifdef FIFO_WR_AFULL_EN
    ,
    output logic                  wafull
`endif
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] rq_sync;
    logic [PW-1:0] rbin_sync;
    logic [PW-1:0] wbin_q;
    logic [PW-1:0] wbin_d;
    logic [PW-1:0] wgray_q;
    logic [PW-1:0] wgray_d;
    logic [PW-1:0] wlevel_q;
    logic [PW-1:0] wlevel_d;
    logic [PW-1:0] full_cmp;
    logic          wfull_q;
    logic          wfull_d;
    logic          wovf_q;
    logic          wovf_d;

    // Plain flop chain; rptr_gray is never used outside it.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rq_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        rbin_sync = '0;
        for (int i = 0; i < PW; i++) begin
            rbin_sync[i] = ^(rq_sync >> i);
        end
    end

    // Gated by w_rst so no write escapes while reset is held.
    assign wclken = winc & ~wfull_q & w_rst;

    assign wbin_d   = wbin_q + {{ADDR_WIDTH{1'b0}}, wclken};
    assign wgray_d  = wbin_d ^ (wbin_d >> 1);
    assign full_cmp = {~rq_sync[PW-1:PW-2], rq_sync[PW-3:0]};
    assign wfull_d  = (wgray_d == full_cmp);
    assign wlevel_d = wbin_d - rbin_sync;
    assign wovf_d   = wovf_q | (winc & wfull_q);

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            wfull_q  <= 1'b0;
            wlevel_q <= '0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wfull_q  <= wfull_d;
            wlevel_q <= wlevel_d;
            wovf_q   <= wovf_d;
        end
    end

    assign waddr     = wbin_q[ADDR_WIDTH-1:0];
    assign wptr_gray = wgray_q;
    assign wfull     = wfull_q;
    assign wlevel    = wlevel_q;
    assign wovf      = wovf_q;

`ifdef FIFO_WR_AFULL_EN
    localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_WIDTH;
    localparam logic [PW-1:0] THR   = PW'(AFULL_THRESH);

    logic [PW-1:0] free_d;
    logic          wafull_q;
    logic          wafull_d;

    assign free_d   = DEPTH - wlevel_d;
    assign wafull_d = (free_d <= THR);

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            wafull_q <= 1'b0;
        end else begin
            wafull_q <= wafull_d;
        end
    end

    assign wafull = wafull_q;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed vector bench for fifo_wr_ctrl (ADDR_WIDTH=4, SYNC_STAGES=2).
module tb_fifo_wr_ctrl;

    logic       w_clk;
    logic       w_rst;
    logic       winc;
    logic [4:0] rptr_gray;
    logic [3:0] waddr;
    logic       wclken;
    logic [4:0] wptr_gray;
    logic       wfull;
    logic [4:0] wlevel;
    logic       wovf;
`ifdef FIFO_WR_AFULL_EN
    logic       wafull;
`endif

    int checks = 0;
    int errors = 0;

    fifo_wr_ctrl #(
        .ADDR_WIDTH  (4),
        .SYNC_STAGES (2),
        .AFULL_THRESH(2)
    ) dut (
        .w_clk    (w_clk),
        .w_rst    (w_rst),
        .winc     (winc),
        .rptr_gray(rptr_gray),
        .waddr    (waddr),
        .wclken   (wclken),
        .wptr_gray(wptr_gray),
        .wfull    (wfull),
        .wlevel   (wlevel),
        .wovf     (wovf)
`ifdef FIFO_WR_AFULL_EN
        ,
        .wafull   (wafull)
`endif
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    typedef struct {
        logic       winc;
        logic [4:0] rptr;
        logic [3:0] waddr;
        logic       wclken;
        logic [4:0] wgray;
        logic       wfull;
        logic [4:0] wlevel;
        logic       wovf;
    } vec_t;

    vec_t vt[21];

    function automatic logic [4:0] g(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge w_clk);
        #1;
    endtask

    task automatic do_reset;
        w_rst = 1'b0;
        winc = 1'b0;
        rptr_gray = '0;
        #3;
        @(negedge w_clk);
        w_rst = 1'b1;
        tick();
    endtask

    initial begin
        // Table: 16 fills, overflow attempt, one read, refill.
        for (int i = 0; i < 16; i++) begin
            vt[i] = '{1'b1, 5'd0, 4'(i), 1'b1, g(i + 1), (i == 15), 5'(i + 1), 1'b0};
        end
        vt[16] = '{1'b1, 5'd0, 4'd0, 1'b0, 5'b11000, 1'b1, 5'd16, 1'b1};
        vt[17] = '{1'b0, 5'd1, 4'd0, 1'b0, 5'b11000, 1'b1, 5'd16, 1'b1};
        vt[18] = '{1'b0, 5'd1, 4'd0, 1'b0, 5'b11000, 1'b1, 5'd16, 1'b1};
        vt[19] = '{1'b0, 5'd1, 4'd0, 1'b0, 5'b11000, 1'b0, 5'd15, 1'b1};
        vt[20] = '{1'b1, 5'd1, 4'd0, 1'b1, 5'b11001, 1'b1, 5'd16, 1'b1};

        w_rst = 1'b0;
        winc = 1'b1;
        rptr_gray = '0;
        #12;
        chk("rst_waddr", 32'(waddr), 0);
        chk("rst_wclken", 32'(wclken), 0);
        chk("rst_wgray", 32'(wptr_gray), 0);
        chk("rst_wfull", 32'(wfull), 0);
        chk("rst_wlevel", 32'(wlevel), 0);
        chk("rst_wovf", 32'(wovf), 0);
        winc = 1'b0;
        @(negedge w_clk);
        w_rst = 1'b1;
        tick();

        for (int i = 0; i < 21; i++) begin
            winc = vt[i].winc;
            rptr_gray = vt[i].rptr;
            #1;
            chk($sformatf("v%0d_waddr", i), 32'(waddr), 32'(vt[i].waddr));
            chk($sformatf("v%0d_wclken", i), 32'(wclken), 32'(vt[i].wclken));
            tick();
            chk($sformatf("v%0d_wgray", i), 32'(wptr_gray), 32'(vt[i].wgray));
            chk($sformatf("v%0d_wfull", i), 32'(wfull), 32'(vt[i].wfull));
            chk($sformatf("v%0d_wlevel", i), 32'(wlevel), 32'(vt[i].wlevel));
            chk($sformatf("v%0d_wovf", i), 32'(wovf), 32'(vt[i].wovf));
        end

        // Random write/read traffic across 100 pointer wraps.
        do_reset();
        begin
            int wcnt = 0;
            int rcnt = 0;
            int cyc = 0;
            logic [4:0] prev;
            logic acc;
            while (wcnt < 1600 && cyc < 20000) begin
                winc = ($urandom_range(0, 3) != 0);
                if (rcnt < wcnt && $urandom_range(0, 3) != 0) rcnt++;
                rptr_gray = g(rcnt);
                #1;
                checks++;
                if (wclken && wfull) begin
                    errors++;
                    $display("FAIL tr_wclken_full actual=1 required=0");
                end
                prev = wptr_gray;
                acc = wclken;
                tick();
                if (acc) wcnt++;
                chk("tr_onebit", 32'($countones(prev ^ wptr_gray)), 32'(acc));
                chk("tr_wgray", 32'(wptr_gray), 32'(g(wcnt)));
                checks++;
                if (wlevel > 5'd16 || int'(wlevel) < wcnt - rcnt) begin
                    errors++;
                    $display("FAIL tr_wlevel actual=%0d required=%0d..16", wlevel, wcnt - rcnt);
                end
                cyc++;
            end
            chk("tr_done", 32'(wcnt >= 1600), 1);
        end

        // Asynchronous reset mid-burst.
        do_reset();
        winc = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("mb_waddr7", 32'(waddr), 7);
        #2;
        w_rst = 1'b0;
        #1;
        chk("mb_waddr", 32'(waddr), 0);
        chk("mb_wclken", 32'(wclken), 0);
        chk("mb_wgray", 32'(wptr_gray), 0);
        chk("mb_wfull", 32'(wfull), 0);
        chk("mb_wlevel", 32'(wlevel), 0);
        chk("mb_wovf", 32'(wovf), 0);
        @(negedge w_clk);
        w_rst = 1'b1;
        #1;
        chk("mb_first_waddr", 32'(waddr), 0);
        chk("mb_first_wclken", 32'(wclken), 1);
        tick();
        chk("mb_first_wgray", 32'(wptr_gray), 1);

`ifdef FIFO_WR_AFULL_EN
        do_reset();
        winc = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        chk("af_13", 32'(wafull), 0);
        tick();
        chk("af_14", 32'(wafull), 1);
        winc = 1'b0;
        rptr_gray = 5'b00001;
        tick();
        tick();
        chk("af_hold", 32'(wafull), 1);
        tick();
        chk("af_fall", 32'(wafull), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
